// File: rtl/mw_lane_reg.sv
// mw_lane_reg: M-to-W pipeline register with a 2-entry skid buffer.
// Holds a memory read word with its byte offset and write-back control.
// Presents the head entry as four byte lanes plus a lane select for the
// W-stage 4:1 byte mux. m_ready is registered from state only, so W-stage
// back-pressure never reaches the M stage combinationally.
module mw_lane_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_addr_lo,
  input  logic [REG_AW-1:0] m_rd,
  input  logic              m_we,
  input  logic              flush,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [7:0]        data_one_mux,
  output logic [7:0]        data_two_mux,
  output logic [7:0]        data_three_mux,
  output logic [7:0]        data_four_mux,
  output logic [1:0]        two_adder_mux,
  output logic [REG_AW-1:0] w_rd,
  output logic              w_we,
  output logic [1:0]        occupancy
);

  // The state encoding doubles as the occupancy count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              m_ready_q, m_ready_d;

  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [1:0]        head_al_q, head_al_d;
  logic [REG_AW-1:0] head_rd_q, head_rd_d;
  logic              head_we_q, head_we_d;

  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [1:0]        skid_al_q, skid_al_d;
  logic [REG_AW-1:0] skid_rd_q, skid_rd_d;
  logic              skid_we_q, skid_we_d;

  logic              accept;
  logic              pop;

  assign w_valid = (state_q != ST_EMPTY);
  assign accept  = m_valid & m_ready_q;
  assign pop     = w_valid & w_ready;

  // Next-state and slot-load selection; flush overrides accept and pop.
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_al_d   = head_al_q;
    head_rd_d   = head_rd_q;
    head_we_d   = head_we_q;
    skid_data_d = skid_data_q;
    skid_al_d   = skid_al_q;
    skid_rd_d   = skid_rd_q;
    skid_we_d   = skid_we_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_ONE;
            head_data_d = m_rdata;
            head_al_d   = m_addr_lo;
            head_rd_d   = m_rd;
            head_we_d   = m_we;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            // Head leaves and the new entry replaces it in the same cycle.
            head_data_d = m_rdata;
            head_al_d   = m_addr_lo;
            head_rd_d   = m_rd;
            head_we_d   = m_we;
          end else if (accept) begin
            state_d     = ST_FULL;
            skid_data_d = m_rdata;
            skid_al_d   = m_addr_lo;
            skid_rd_d   = m_rd;
            skid_we_d   = m_we;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // m_ready is low here, so only a pop can move the state.
          if (pop) begin
            state_d     = ST_ONE;
            head_data_d = skid_data_q;
            head_al_d   = skid_al_q;
            head_rd_d   = skid_rd_q;
            head_we_d   = skid_we_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign m_ready_d = (state_d != ST_FULL);

  // Control registers; m_ready stays low through reset and rises on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      m_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_ready_q <= m_ready_d;
    end
  end

  // Entry slots; cleared on reset so no stale word can be observed afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data_q <= '0;
      head_al_q   <= '0;
      head_rd_q   <= '0;
      head_we_q   <= 1'b0;
      skid_data_q <= '0;
      skid_al_q   <= '0;
      skid_rd_q   <= '0;
      skid_we_q   <= 1'b0;
    end else begin
      head_data_q <= head_data_d;
      head_al_q   <= head_al_d;
      head_rd_q   <= head_rd_d;
      head_we_q   <= head_we_d;
      skid_data_q <= skid_data_d;
      skid_al_q   <= skid_al_d;
      skid_rd_q   <= skid_rd_d;
      skid_we_q   <= skid_we_d;
    end
  end

  assign m_ready        = m_ready_q;
  assign occupancy      = state_q;
  assign data_one_mux   = head_data_q[7:0];
  assign data_two_mux   = head_data_q[15:8];
  assign data_three_mux = head_data_q[23:16];
  assign data_four_mux  = head_data_q[31:24];
  assign two_adder_mux  = head_al_q;
  assign w_rd           = head_rd_q;
  assign w_we           = w_valid & head_we_q;

endmodule

// File: tb/tb_mw_lane_reg.sv
// tb_mw_lane_reg: table-driven bench for the M-to-W skid register, with
// hand-written sequences for streaming and asynchronous reset.
module tb_mw_lane_reg;

  logic        clk;
  logic        rst_n;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic [1:0]  m_addr_lo;
  logic [4:0]  m_rd;
  logic        m_we;
  logic        flush;
  logic        w_valid;
  logic        w_ready;
  logic [7:0]  data_one_mux;
  logic [7:0]  data_two_mux;
  logic [7:0]  data_three_mux;
  logic [7:0]  data_four_mux;
  logic [1:0]  two_adder_mux;
  logic [4:0]  w_rd;
  logic        w_we;
  logic [1:0]  occupancy;

  int tests;
  int fails;

  mw_lane_reg #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_ready(m_ready), .m_rdata(m_rdata),
    .m_addr_lo(m_addr_lo), .m_rd(m_rd), .m_we(m_we), .flush(flush),
    .w_valid(w_valid), .w_ready(w_ready),
    .data_one_mux(data_one_mux), .data_two_mux(data_two_mux),
    .data_three_mux(data_three_mux), .data_four_mux(data_four_mux),
    .two_adder_mux(two_adder_mux), .w_rd(w_rd), .w_we(w_we),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mv;
    logic [31:0] dat;
    logic [1:0]  al;
    logic [4:0]  rd;
    logic        we;
    logic        fl;
    logic        wr;
    logic        e_wv;
    logic        e_mr;
    logic [1:0]  e_occ;
    logic [31:0] e_dat;
    logic [1:0]  e_al;
    logic [4:0]  e_rd;
    logic        e_we;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  function automatic vec_t mk(logic mv, logic [31:0] dat, logic [1:0] al, logic [4:0] rd,
                              logic we, logic fl, logic wr, logic e_wv, logic e_mr,
                              logic [1:0] e_occ, logic [31:0] e_dat, logic [1:0] e_al,
                              logic [4:0] e_rd, logic e_we);
    vec_t v;
    v.mv = mv; v.dat = dat; v.al = al; v.rd = rd; v.we = we; v.fl = fl; v.wr = wr;
    v.e_wv = e_wv; v.e_mr = e_mr; v.e_occ = e_occ; v.e_dat = e_dat;
    v.e_al = e_al; v.e_rd = e_rd; v.e_we = e_we;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_wv, input logic e_mr,
                         input logic [1:0] e_occ, input logic [31:0] e_dat,
                         input logic [1:0] e_al, input logic [4:0] e_rd, input logic e_we);
    chk({tag, ".w_valid"}, {31'd0, w_valid}, {31'd0, e_wv});
    chk({tag, ".m_ready"}, {31'd0, m_ready}, {31'd0, e_mr});
    chk({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, e_occ});
    chk({tag, ".lanes"}, {data_four_mux, data_three_mux, data_two_mux, data_one_mux}, e_dat);
    chk({tag, ".two_adder_mux"}, {30'd0, two_adder_mux}, {30'd0, e_al});
    chk({tag, ".w_rd"}, {27'd0, w_rd}, {27'd0, e_rd});
    chk({tag, ".w_we"}, {31'd0, w_we}, {31'd0, e_we});
  endtask

  task automatic drive(input logic mv, input logic [31:0] dat, input logic [1:0] al,
                       input logic [4:0] rd, input logic we, input logic fl, input logic wr);
    m_valid = mv; m_rdata = dat; m_addr_lo = al; m_rd = rd; m_we = we;
    flush = fl; w_ready = wr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1);

    //        mv  data           al  rd   we fl wr   wv mr occ e_data        al  rd   we
    vecs[0]  = mk(0, 32'h00000000, 0, 0,  0, 0, 1,   0, 1, 0, 32'h00000000, 0, 0,  0);
    vecs[1]  = mk(1, 32'hA1B2C3D4, 2, 5,  1, 0, 1,   1, 1, 1, 32'hA1B2C3D4, 2, 5,  1);
    vecs[2]  = mk(0, 32'h00000000, 0, 0,  0, 0, 1,   0, 1, 0, 32'hA1B2C3D4, 2, 5,  0);
    vecs[3]  = mk(1, 32'h11111111, 1, 1,  1, 0, 0,   1, 1, 1, 32'h11111111, 1, 1,  1);
    vecs[4]  = mk(1, 32'h22222222, 3, 2,  1, 0, 0,   1, 0, 2, 32'h11111111, 1, 1,  1);
    vecs[5]  = mk(1, 32'h33333333, 0, 4,  1, 0, 0,   1, 0, 2, 32'h11111111, 1, 1,  1);
    vecs[6]  = mk(0, 32'h00000000, 0, 0,  0, 0, 1,   1, 1, 1, 32'h22222222, 3, 2,  1);
    vecs[7]  = mk(0, 32'h00000000, 0, 0,  0, 0, 1,   0, 1, 0, 32'h22222222, 3, 2,  0);
    vecs[8]  = mk(1, 32'hFFFFFFFF, 0, 31, 0, 0, 0,   1, 1, 1, 32'hFFFFFFFF, 0, 31, 0);
    vecs[9]  = mk(1, 32'h12345678, 1, 7,  1, 0, 1,   1, 1, 1, 32'h12345678, 1, 7,  1);
    vecs[10] = mk(1, 32'hAAAA0001, 0, 3,  1, 0, 0,   1, 0, 2, 32'h12345678, 1, 7,  1);
    vecs[11] = mk(1, 32'hDEADBEEF, 3, 9,  1, 1, 1,   0, 1, 0, 32'h12345678, 1, 7,  0);
    vecs[12] = mk(1, 32'h55555555, 2, 9,  1, 0, 0,   1, 1, 1, 32'h55555555, 2, 9,  1);
    vecs[13] = mk(1, 32'h66666666, 3, 6,  1, 1, 1,   0, 1, 0, 32'h55555555, 2, 9,  0);
    vecs[14] = mk(0, 32'h00000000, 0, 0,  0, 0, 1,   0, 1, 0, 32'h55555555, 2, 9,  0);

    // Reset state while rst_n is held low.
    #12;
    chk_all("reset", 1'b0, 1'b0, 2'd0, 32'h0, 2'd0, 5'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven sequence: load, back-pressure fill/drain, we=0, flush priority.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].mv, vecs[i].dat, vecs[i].al, vecs[i].rd, vecs[i].we, vecs[i].fl, vecs[i].wr);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].e_wv, vecs[i].e_mr, vecs[i].e_occ,
              vecs[i].e_dat, vecs[i].e_al, vecs[i].e_rd, vecs[i].e_we);
    end

    // Streaming: one word per cycle, each visible one cycle later, occupancy pinned at 1.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] w;
      w = 32'h10203040 + 32'(i);
      @(negedge clk);
      drive(1'b1, w, 2'(i), 5'(i + 8), 1'b1, 1'b0, 1'b1);
      tick();
      chk_all($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, w, 2'(i), 5'(i + 8), 1'b1);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("stream_drain.w_valid", {31'd0, w_valid}, 32'd0);

    // Async reset while FULL: outputs clear without waiting for a clock edge.
    @(negedge clk);
    drive(1'b1, 32'hBEEF0001, 2'd1, 5'd11, 1'b1, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    drive(1'b1, 32'hBEEF0002, 2'd2, 5'd12, 1'b1, 1'b0, 1'b0);
    tick();
    chk("prereset.occupancy", {30'd0, occupancy}, 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 2'd0, 32'h0, 2'd0, 5'd0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    tick();
    chk_all("post_rst_idle", 1'b0, 1'b1, 2'd0, 32'h0, 2'd0, 5'd0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'hCAFEF00D, 2'd3, 5'd20, 1'b1, 1'b0, 1'b1);
    tick();
    chk_all("post_rst_load", 1'b1, 1'b1, 2'd1, 32'hCAFEF00D, 2'd3, 5'd20, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all("post_rst_pop", 1'b0, 1'b1, 2'd0, 32'hCAFEF00D, 2'd3, 5'd20, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
